pic_file_access_ctrl: RTL and testbench

Initiator side of the PIC16C57 register-file port: accepts one decoded byte- or bit-oriented file-register instruction at a time, drives the register file's address, write, data and status-update inputs through a fixed read-modify-write sequence, and holds the W register. It sits between the instruction decoder and the register file. It implements the ALU results and C/DC/Z flag generation for file operations, and reports skip conditions to the program sequencer.

---
 rtl/pic_file_access_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_pic_file_access_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_file_access_ctrl.sv
// pic_file_access_ctrl
// Register-file initiator for a PIC16C57-style core. It runs one byte- or
// bit-oriented file instruction at a time through a fixed read-modify-write
// sequence: IDLE, ADDR, READ, EXEC, WRITE, FLAGS, optional WAIT, DONE.
// It computes the ALU result and the C/DC/Z flags, and it holds W.
// Optional feature macro: PIC_FILE_SKIP_EN. When it is defined,
// BTFSC/BTFSS/INCFSZ/DECFSZ are implemented and drive `skip`. When it is
// undefined, those four opcodes behave as NOP and `skip` stays low.
module pic_file_access_ctrl #(
    parameter int SKIP_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reqValid,
    output logic       reqReady,
    input  logic [4:0] reqOp,
    input  logic [4:0] reqFile,
    input  logic       reqDest,
    input  logic [2:0] reqBit,
    output logic       ack,
    output logic       skip,
    output logic [7:0] wOut,
    output logic [4:0] rfAddress,
    output logic       rfWrite,
    output logic [7:0] rfDataOut,
    output logic       rfStatusEn,
    output logic [7:0] rfStatusOut,
    input  logic [7:0] rfDataIn,
    input  logic [7:0] rfStatusIn
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_FLAGS = 3'd5;
    localparam logic [2:0] ST_WAIT  = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    localparam logic [4:0] OP_MOVWF  = 5'h01;
    localparam logic [4:0] OP_CLRF   = 5'h02;
    localparam logic [4:0] OP_CLRW   = 5'h03;
    localparam logic [4:0] OP_MOVF   = 5'h04;
    localparam logic [4:0] OP_INCF   = 5'h05;
    localparam logic [4:0] OP_DECF   = 5'h06;
    localparam logic [4:0] OP_ADDWF  = 5'h07;
    localparam logic [4:0] OP_SUBWF  = 5'h08;
    localparam logic [4:0] OP_ANDWF  = 5'h09;
    localparam logic [4:0] OP_IORWF  = 5'h0A;
    localparam logic [4:0] OP_XORWF  = 5'h0B;
    localparam logic [4:0] OP_COMF   = 5'h0C;
    localparam logic [4:0] OP_SWAPF  = 5'h0D;
    localparam logic [4:0] OP_RLF    = 5'h0E;
    localparam logic [4:0] OP_RRF    = 5'h0F;
    localparam logic [4:0] OP_BCF    = 5'h10;
    localparam logic [4:0] OP_BSF    = 5'h11;
`ifdef PIC_FILE_SKIP_EN
    localparam logic [4:0] OP_BTFSC  = 5'h12;
    localparam logic [4:0] OP_BTFSS  = 5'h13;
    localparam logic [4:0] OP_INCFSZ = 5'h14;
    localparam logic [4:0] OP_DECFSZ = 5'h15;
`endif

    // Flag mask / flag vector layout matches STATUS[2:0]: {Z, DC, C}.
    localparam logic [2:0] FL_C   = 3'b001;
    localparam logic [2:0] FL_Z   = 3'b100;
    localparam logic [2:0] FL_CDZ = 3'b111;

    localparam logic [1:0] LAT_M1 = (SKIP_LAT > 0) ? 2'(SKIP_LAT - 1) : 2'd0;

    logic [2:0] state;
    logic [1:0] wait_cnt;
    logic [4:0] op_reg;
    logic       dest_reg;
    logic [2:0] bit_reg;
    logic [7:0] res_reg;
    logic [2:0] flag_reg;
    logic [2:0] mask_reg;
    logic       wr_w_reg;
    logic       skip_reg;

    logic [8:0] sum9;
    logic [8:0] dif9;
    logic [4:0] nib_sum;
    logic [7:0] bit_mask;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_dc;
    logic       alu_z;
    logic [2:0] alu_mask;
    logic       alu_wr_f;
    logic       alu_wr_w;
    logic       alu_skip;
    logic       use_dest;

    // Replace the affected C/DC/Z bits of STATUS and keep the remaining bits.
    function automatic logic [7:0] merge_status(input logic [7:0] st,
                                                input logic [2:0] mask,
                                                input logic [2:0] flags);
        merge_status = {st[7:3], (st[2:0] & ~mask) | (flags & mask)};
    endfunction

    assign reqReady    = (state == ST_IDLE) && !rst;
    assign sum9        = {1'b0, rfDataIn} + {1'b0, wOut};
    assign dif9        = {1'b0, rfDataIn} - {1'b0, wOut};
    assign nib_sum     = {1'b0, rfDataIn[3:0]} + {1'b0, wOut[3:0]};
    assign bit_mask    = 8'h01 << bit_reg;
    assign alu_z       = (alu_res == 8'h00);
    // STATUS is sampled during FLAGS, so a WRITE to STATUS is already visible here.
    assign rfStatusOut = (state == ST_FLAGS) ? merge_status(rfStatusIn, mask_reg, flag_reg) : 8'h00;

    // EXEC-stage ALU: the result, the flags, the destination and the skip condition.
    always_comb begin
        alu_res  = 8'h00;
        alu_c    = 1'b0;
        alu_dc   = 1'b0;
        alu_mask = 3'b000;
        alu_wr_f = 1'b0;
        alu_wr_w = 1'b0;
        alu_skip = 1'b0;
        use_dest = 1'b0;
        case (op_reg)
            OP_MOVWF: begin alu_res = wOut; alu_wr_f = 1'b1; end
            OP_CLRF:  begin alu_wr_f = 1'b1; alu_mask = FL_Z; end
            OP_CLRW:  begin alu_wr_w = 1'b1; alu_mask = FL_Z; end
            OP_MOVF:  begin alu_res = rfDataIn; use_dest = 1'b1; alu_mask = FL_Z; end
            OP_INCF:  begin alu_res = rfDataIn + 8'd1; use_dest = 1'b1; alu_mask = FL_Z; end
            OP_DECF:  begin alu_res = rfDataIn - 8'd1; use_dest = 1'b1; alu_mask = FL_Z; end
            OP_ADDWF: begin
                alu_res  = sum9[7:0];
                alu_c    = sum9[8];
                alu_dc   = nib_sum[4];
                use_dest = 1'b1;
                alu_mask = FL_CDZ;
            end
            OP_SUBWF: begin
                // C and DC are active-low borrows.
                alu_res  = dif9[7:0];
                alu_c    = ~dif9[8];
                alu_dc   = (rfDataIn[3:0] >= wOut[3:0]);
                use_dest = 1'b1;
                alu_mask = FL_CDZ;
            end
            OP_ANDWF: begin alu_res = rfDataIn & wOut; use_dest = 1'b1; alu_mask = FL_Z; end
            OP_IORWF: begin alu_res = rfDataIn | wOut; use_dest = 1'b1; alu_mask = FL_Z; end
            OP_XORWF: begin alu_res = rfDataIn ^ wOut; use_dest = 1'b1; alu_mask = FL_Z; end
            OP_COMF:  begin alu_res = ~rfDataIn; use_dest = 1'b1; alu_mask = FL_Z; end
            OP_SWAPF: begin alu_res = {rfDataIn[3:0], rfDataIn[7:4]}; use_dest = 1'b1; end
            OP_RLF: begin
                alu_res  = {rfDataIn[6:0], rfStatusIn[0]};
                alu_c    = rfDataIn[7];
                use_dest = 1'b1;
                alu_mask = FL_C;
            end
            OP_RRF: begin
                alu_res  = {rfStatusIn[0], rfDataIn[7:1]};
                alu_c    = rfDataIn[0];
                use_dest = 1'b1;
                alu_mask = FL_C;
            end
            OP_BCF: begin alu_res = rfDataIn & ~bit_mask; alu_wr_f = 1'b1; end
            OP_BSF: begin alu_res = rfDataIn | bit_mask; alu_wr_f = 1'b1; end
`ifdef PIC_FILE_SKIP_EN
            OP_BTFSC:  alu_skip = ~rfDataIn[bit_reg];
            OP_BTFSS:  alu_skip = rfDataIn[bit_reg];
            OP_INCFSZ: begin alu_res = rfDataIn + 8'd1; use_dest = 1'b1; alu_skip = (rfDataIn == 8'hFF); end
            OP_DECFSZ: begin alu_res = rfDataIn - 8'd1; use_dest = 1'b1; alu_skip = (rfDataIn == 8'h01); end
`endif
            default: ;
        endcase
        if (use_dest) begin
            alu_wr_f = dest_reg;
            alu_wr_w = ~dest_reg;
        end
    end

    // Sequencer and registered outputs. A reset clears them and aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= 2'd0;
            ack        <= 1'b0;
            skip       <= 1'b0;
            rfWrite    <= 1'b0;
            rfStatusEn <= 1'b0;
            rfAddress  <= 5'd0;
            rfDataOut  <= 8'h00;
            wOut       <= 8'h00;
        end else begin
            ack  <= 1'b0;
            skip <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (reqValid) begin
                        rfAddress <= reqFile;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: state <= ST_READ;
                ST_READ: state <= ST_EXEC;
                ST_EXEC: begin
                    rfWrite   <= alu_wr_f;
                    rfDataOut <= alu_res;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    // write and StatusEn must fall in separate cycles, so StatusEn follows in FLAGS.
                    rfWrite    <= 1'b0;
                    rfStatusEn <= |mask_reg;
                    if (wr_w_reg) begin
                        wOut <= res_reg;
                    end
                    state <= ST_FLAGS;
                end
                ST_FLAGS: begin
                    rfStatusEn <= 1'b0;
                    wait_cnt   <= LAT_M1;
                    if (SKIP_LAT == 0) begin
                        ack   <= 1'b1;
                        skip  <= skip_reg;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        ack   <= 1'b1;
                        skip  <= skip_reg;
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Instruction fields and EXEC results. These are datapath registers and are not reset.
    always_ff @(posedge clk) begin
        if (reqReady && reqValid) begin
            op_reg   <= reqOp;
            dest_reg <= reqDest;
            bit_reg  <= reqBit;
        end
        if (state == ST_EXEC) begin
            res_reg  <= alu_res;
            flag_reg <= {alu_z, alu_dc, alu_c};
            mask_reg <= alu_mask;
            wr_w_reg <= alu_wr_w;
            skip_reg <= alu_skip;
        end
    end

endmodule

// File: tb/tb_pic_file_access_ctrl.sv
// Testbench for pic_file_access_ctrl. It contains a simple register-file
// environment plus a reference model of the file-op results, the flags and
// the skip behaviour. The model's memory and W are compared with the DUT.
module tb_pic_file_access_ctrl;
    localparam int SKIP_LAT = 0;
    localparam int LAST     = 6 + SKIP_LAT;
`ifdef PIC_FILE_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reqValid = 1'b0;
    logic       reqReady;
    logic [4:0] reqOp = 5'd0;
    logic [4:0] reqFile = 5'd0;
    logic       reqDest = 1'b0;
    logic [2:0] reqBit = 3'd0;
    logic       ack;
    logic       skip;
    logic [7:0] wOut;
    logic [4:0] rfAddress;
    logic       rfWrite;
    logic [7:0] rfDataOut;
    logic       rfStatusEn;
    logic [7:0] rfStatusOut;
    logic [7:0] rfDataIn;
    logic [7:0] rfStatusIn;

    logic [7:0] rf [32];
    logic [7:0] rf_out;
    logic       pl_en = 1'b0;
    logic [4:0] pl_addr = 5'd0;
    logic [7:0] pl_data = 8'h00;

    logic [7:0] mem_m [32];
    logic [7:0] w_m;
    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] obs_wdata;
    logic [7:0] obs_status;
    logic       obs_skip;
    logic       obs_wr;
    logic       obs_sten;
    int         obs_ack_cycle;

    pic_file_access_ctrl #(.SKIP_LAT(SKIP_LAT)) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
        .reqOp(reqOp), .reqFile(reqFile), .reqDest(reqDest), .reqBit(reqBit),
        .ack(ack), .skip(skip), .wOut(wOut), .rfAddress(rfAddress),
        .rfWrite(rfWrite), .rfDataOut(rfDataOut), .rfStatusEn(rfStatusEn),
        .rfStatusOut(rfStatusOut), .rfDataIn(rfDataIn), .rfStatusIn(rfStatusIn)
    );

    always #5 clk = ~clk;

    // Register file: registered read, and write takes priority over StatusEn. STATUS lives at 0x03.
    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (rfWrite) rf[rfAddress] <= rfDataOut;
        else if (rfStatusEn) rf[3] <= rfStatusOut;
        rf_out <= rf[rfAddress];
    end
    assign rfDataIn   = rf_out;
    assign rfStatusIn = rf[3];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference semantics of one file op, computed with plain integer arithmetic.
    task automatic model_op(input int op_in, input bit d, input int b, input int fv, input int w,
                            input bit cin, output int r, output bit wf, output bit ww,
                            output int mask, output int fl, output bit sk);
        int op;
        int c;
        int dc;
        bit to_dest;
        op = op_in;
        r = 0; wf = 0; ww = 0; mask = 0; c = 0; dc = 0; sk = 0; to_dest = 0;
        if (!SKIP_EN && op >= 'h12 && op <= 'h15) op = 0;
        case (op)
            'h01: begin r = w; wf = 1; end
            'h02: begin r = 0; wf = 1; mask = 4; end
            'h03: begin r = 0; ww = 1; mask = 4; end
            'h04: begin r = fv; to_dest = 1; mask = 4; end
            'h05: begin r = (fv + 1) % 256; to_dest = 1; mask = 4; end
            'h06: begin r = (fv + 255) % 256; to_dest = 1; mask = 4; end
            'h07: begin
                r = (fv + w) % 256; to_dest = 1; mask = 7;
                c  = ((fv + w) > 255) ? 1 : 0;
                dc = ((fv % 16 + w % 16) > 15) ? 1 : 0;
            end
            'h08: begin
                r = (fv - w + 256) % 256; to_dest = 1; mask = 7;
                c  = (fv >= w) ? 1 : 0;
                dc = ((fv % 16) >= (w % 16)) ? 1 : 0;
            end
            'h09: begin r = fv & w; to_dest = 1; mask = 4; end
            'h0A: begin r = fv | w; to_dest = 1; mask = 4; end
            'h0B: begin r = fv ^ w; to_dest = 1; mask = 4; end
            'h0C: begin r = 255 - fv; to_dest = 1; mask = 4; end
            'h0D: begin r = (fv % 16) * 16 + fv / 16; to_dest = 1; end
            'h0E: begin r = (fv * 2) % 256 + (cin ? 1 : 0); c = fv / 128; to_dest = 1; mask = 1; end
            'h0F: begin r = fv / 2 + (cin ? 128 : 0); c = fv % 2; to_dest = 1; mask = 1; end
            'h10: begin r = fv & (255 - (1 << b)); wf = 1; end
            'h11: begin r = fv | (1 << b); wf = 1; end
            'h12: sk = (((fv >> b) & 1) == 0);
            'h13: sk = (((fv >> b) & 1) == 1);
            'h14: begin r = (fv + 1) % 256; to_dest = 1; sk = (r == 0); end
            'h15: begin r = (fv + 255) % 256; to_dest = 1; sk = (r == 0); end
            default: ;
        endcase
        if (to_dest) begin wf = d; ww = !d; end
        fl = c + 2 * dc + ((r == 0) ? 4 : 0);
    endtask

    task automatic poke(input logic [4:0] a, input logic [7:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        @(negedge clk);
        pl_en = 1'b0;
        mem_m[a] = v;
    endtask

    // Issue one instruction and check every output on every cycle up to the first IDLE cycle after it.
    task automatic run_instr(input logic [4:0] op, input logic [4:0] f, input logic d,
                             input logic [2:0] b, input bit hold);
        int r, mask, fl, fv, w_old, w_new, st_new, waited;
        bit wf, ww, sk;
        fv = int'(mem_m[f]);
        w_old = int'(w_m);
        model_op(int'(op), d, int'(b), fv, w_old, mem_m[3][0], r, wf, ww, mask, fl, sk);
        w_new = ww ? r : w_old;
        if (wf) mem_m[f] = 8'(r);
        st_new = (int'(mem_m[3]) & ~mask) | (fl & mask);
        mem_m[3] = 8'(st_new);
        w_m = 8'(w_new);

        @(negedge clk);
        waited = 0;
        while (!reqReady && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_idle", 32'(reqReady), 32'd1);
        reqValid = 1'b1; reqOp = op; reqFile = f; reqDest = d; reqBit = b;
        @(posedge clk);
        obs_wr = 0; obs_sten = 0; obs_skip = 0; obs_ack_cycle = -1;
        obs_wdata = 8'h00; obs_status = 8'h00;
        for (int k = 1; k <= LAST; k++) begin
            @(negedge clk);
            if (hold) begin
                reqOp = 5'($urandom); reqFile = 5'($urandom);
                reqDest = 1'($urandom); reqBit = 3'($urandom);
            end else begin
                reqValid = 1'b0;
            end
            check("busy_ready", 32'(reqReady), 32'd0);
            check("rfAddress", 32'(rfAddress), 32'(f));
            check("rfWrite", 32'(rfWrite), (k == 4 && wf) ? 32'd1 : 32'd0);
            check("rfStatusEn", 32'(rfStatusEn), (k == 5 && mask != 0) ? 32'd1 : 32'd0);
            check("ack", 32'(ack), (k == LAST) ? 32'd1 : 32'd0);
            check("wOut", 32'(wOut), (k >= 5) ? 32'(w_new) : 32'(w_old));
            if (rfWrite) begin obs_wr = 1; obs_wdata = rfDataOut; end
            if (rfStatusEn) begin obs_sten = 1; obs_status = rfStatusOut; end
            if (k == 4 && wf) check("rfDataOut", 32'(rfDataOut), 32'(r));
            if (k == 5 && mask != 0) check("rfStatusOut", 32'(rfStatusOut), 32'(st_new));
            if (ack) begin obs_ack_cycle = k; obs_skip = skip; end
            if (k == LAST) check("skip", 32'(skip), 32'(sk));
        end
        @(negedge clk);
        check("ready_after_done", 32'(reqReady), 32'd1);
        reqValid = 1'b0;
        check("rf_f", 32'(rf[f]), 32'(mem_m[f]));
        check("rf_status", 32'(rf[3]), 32'(mem_m[3]));
        check("wOut_final", 32'(wOut), 32'(w_m));
    endtask

    task automatic set_w(input logic [7:0] v);
        poke(5'h1F, v);
        run_instr(5'h04, 5'h1F, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        int r, mask, fl;
        bit wf, ww, sk;
        w_m = 8'h00;
        for (int i = 0; i < 32; i++) poke(5'(i), 8'($urandom));
        @(negedge clk);
        check("rst_ready", 32'(reqReady), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_skip", 32'(skip), 32'd0);
        check("rst_rfWrite", 32'(rfWrite), 32'd0);
        check("rst_rfStatusEn", 32'(rfStatusEn), 32'd0);
        check("rst_rfAddress", 32'(rfAddress), 32'd0);
        check("rst_rfDataOut", 32'(rfDataOut), 32'd0);
        check("rst_rfStatusOut", 32'(rfStatusOut), 32'd0);
        check("rst_wOut", 32'(wOut), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(reqReady), 32'd1);

        // Literal pins on the model.
        model_op('h07, 1'b1, 0, 'hC8, 'h3A, 1'b0, r, wf, ww, mask, fl, sk);
        check("model_add_r", 32'(r), 32'h02);
        check("model_add_fl", 32'(fl), 32'd3);
        model_op('h08, 1'b0, 0, 'h03, 'h05, 1'b0, r, wf, ww, mask, fl, sk);
        check("model_sub_r", 32'(r), 32'hFE);
        check("model_sub_fl", 32'(fl), 32'd0);

        // MOVWF W=0 then MOVF d=0: Z set, W stays 0, no write.
        run_instr(5'h01, 5'h10, 1'b0, 3'd0, 1'b0);
        run_instr(5'h04, 5'h10, 1'b0, 3'd0, 1'b0);
        check("movf_ack_cycle", 32'(obs_ack_cycle), 32'(6 + SKIP_LAT));
        check("movf_w", 32'(wOut), 32'h00);
        check("movf_z", 32'(rf[3][2]), 32'd1);
        check("movf_nowrite", 32'(obs_wr), 32'd0);

        // ADDWF 0xC8 + 0x3A.
        poke(5'h0C, 8'hC8);
        set_w(8'h3A);
        run_instr(5'h07, 5'h0C, 1'b1, 3'd0, 1'b1);
        check("addwf_wdata", 32'(obs_wdata), 32'h02);
        check("addwf_flags", 32'(obs_status[2:0]), 32'd3);

        // SUBWF 0x03 - 0x05 into W.
        poke(5'h0D, 8'h03);
        set_w(8'h05);
        run_instr(5'h08, 5'h0D, 1'b0, 3'd0, 1'b0);
        check("subwf_w", 32'(wOut), 32'hFE);
        check("subwf_c", 32'(rf[3][0]), 32'd0);
        check("subwf_z", 32'(rf[3][2]), 32'd0);

        // INCFSZ on 0xFF.
        poke(5'h08, 8'hFF);
        run_instr(5'h14, 5'h08, 1'b1, 3'd0, 1'b0);
        check("incfsz_data", 32'(rf[8]), SKIP_EN ? 32'h00 : 32'hFF);
        check("incfsz_skip", 32'(obs_skip), 32'(SKIP_EN));
        check("incfsz_nostatus", 32'(obs_sten), 32'd0);

        // RLF through carry, then BTFSS on bit 0.
        poke(5'h03, 8'h01);
        poke(5'h09, 8'h80);
        run_instr(5'h0E, 5'h09, 1'b1, 3'd0, 1'b0);
        check("rlf_data", 32'(rf[9]), 32'h01);
        check("rlf_c", 32'(rf[3][0]), 32'd1);
        run_instr(5'h13, 5'h09, 1'b0, 3'd0, 1'b0);
        check("btfss_skip", 32'(obs_skip), 32'(SKIP_EN));

        // Reset in cycle 3 of an ADDWF aborts the instruction.
        @(negedge clk);
        reqValid = 1'b1; reqOp = 5'h07; reqFile = 5'h0C; reqDest = 1'b1; reqBit = 3'd0;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_c3_nowrite", 32'(rfWrite), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_rfWrite", 32'(rfWrite), 32'd0);
        check("abort_rfStatusEn", 32'(rfStatusEn), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_skip", 32'(skip), 32'd0);
        check("abort_rfAddress", 32'(rfAddress), 32'd0);
        check("abort_rfDataOut", 32'(rfDataOut), 32'd0);
        check("abort_rfStatusOut", 32'(rfStatusOut), 32'd0);
        check("abort_wOut", 32'(wOut), 32'd0);
        check("abort_ready_in_rst", 32'(reqReady), 32'd0);
        rst = 1'b0;
        w_m = 8'h00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("abort_idle_write", 32'(rfWrite), 32'd0);
            check("abort_idle_sten", 32'(rfStatusEn), 32'd0);
            check("abort_idle_ack", 32'(ack), 32'd0);
            check("abort_idle_ready", 32'(reqReady), 32'd1);
        end
        check("abort_mem", 32'(rf[12]), 32'(mem_m[12]));
        check("abort_status", 32'(rf[3]), 32'(mem_m[3]));

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) poke(5'($urandom), 8'($urandom));
            run_instr(5'($urandom_range(0, 23)), 5'($urandom_range(0, 31)),
                      1'($urandom), 3'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
